// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the BCD digit path.
// Shared between the digit counter and the code converter bench so both
// agree on the digit width and legal range.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t DIGIT_MAX = 4'd9;
  localparam digit_t DIGIT_MIN = 4'd0;

  // True when the value is a legal BCD digit.
  function automatic logic is_bcd(input digit_t val);
    return (val <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_counter_btn_debounce.sv
// btn_debounce: synchroniser, debounce filter and press detector for one
// raw push-button.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   raw    raw, asynchronous, bouncing button input
//   level  debounced (accepted) button level
//   press  one-cycle pulse on the first cycle level is high after being low
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   level_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      level_q <= level;
      // Any cycle where the synchronised level agrees with the accepted one
      // restarts qualification, so only an unbroken run can flip level.
      if (sync_lvl == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        level <= sync_lvl;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Rising edge of the accepted level only; releases are ignored.
  assign press = level & ~level_q;

endmodule

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: registered BCD digit stepped by two debounced buttons,
// with a synchronous parallel load. Feeds the 4-bit code converter.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   btn_up      raw increment button
//   btn_down    raw decrement button
//   load        synchronous load strobe
//   load_val    value to load (legal 0-9)
//   digit       current BCD digit, registered
//   step_pulse  digit changed this cycle (step or load)
//   carry       increment wrapped 9 -> 0
//   borrow      decrement wrapped 0 -> 9
//   load_err    load of an out-of-range value was rejected
module bcd_digit_counter
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               step_pulse,
  output logic               carry,
  output logic               borrow,
  output logic               load_err
);

  logic   up_level, up_press;
  logic   down_level, down_press;
  digit_t digit_d;
  logic   step_d, carry_d, borrow_d, load_err_d;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_up (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_up),
    .level(up_level),
    .press(up_press)
  );

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_down (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_down),
    .level(down_level),
    .press(down_press)
  );

  // Load always wins; a press coinciding with any load is dropped rather
  // than queued, since press is a single-cycle pulse.
  always_comb begin
    digit_d    = digit;
    step_d     = 1'b0;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (is_bcd(load_val)) begin
        digit_d = load_val;
        step_d  = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (up_press && down_press) begin
      digit_d = digit;
    end else if (up_press) begin
      step_d = 1'b1;
      if (digit == DIGIT_MAX) begin
        digit_d = DIGIT_MIN;
        carry_d = 1'b1;
      end else begin
        digit_d = digit + DIGIT_W'(1);
      end
    end else if (down_press) begin
      step_d = 1'b1;
      if (digit == DIGIT_MIN) begin
        digit_d  = DIGIT_MAX;
        borrow_d = 1'b1;
      end else begin
        digit_d = digit - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit      <= DIGIT_MIN;
      step_pulse <= 1'b0;
      carry      <= 1'b0;
      borrow     <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      digit      <= digit_d;
      step_pulse <= step_d;
      carry      <= carry_d;
      borrow     <= borrow_d;
      load_err   <= load_err_d;
    end
  end

  a_digit_bcd : assert property (@(posedge clk) disable iff (rst) is_bcd(digit));
  a_up_press_level : assert property (@(posedge clk) disable iff (rst) up_press |-> up_level);
  a_dn_press_level : assert property (@(posedge clk) disable iff (rst) down_press |-> down_level);

endmodule

// File: tb/tb_bcd_digit_counter.sv
// tb_bcd_digit_counter: scoreboard bench for bcd_digit_counter with
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Stimulus pushes expected strobe events
// (with the cycle they must appear in) and steady-state probes; a monitor
// process does all comparing.
module tb_bcd_digit_counter;
  import bcd_pkg::*;

  typedef struct {
    logic [3:0] d;
    logic       s;
    logic       c;
    logic       b;
    logic       e;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] digit;
  logic       step_pulse, carry, borrow, load_err;

  logic probe = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t eq[$];
  exp_t pq[$];

  bcd_digit_counter #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .load      (load),
    .load_val  (load_val),
    .digit     (digit),
    .step_pulse(step_pulse),
    .carry     (carry),
    .borrow    (borrow),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    exp_t e;
    while (eq.size() > 0 && eq[0].cyc < cyc) begin
      e = eq.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missed_event: no strobe seen, required digit=%0d at cycle %0d", e.d, e.cyc);
    end
    if (!rst && (step_pulse || carry || borrow || load_err)) begin
      n_vec++;
      if (eq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: cycle %0d got digit=%0d step=%b carry=%b borrow=%b err=%b, required none",
                 cyc, digit, step_pulse, carry, borrow, load_err);
      end else begin
        e = eq.pop_front();
        if (digit !== e.d || step_pulse !== e.s || carry !== e.c || borrow !== e.b ||
            load_err !== e.e || cyc != e.cyc) begin
          n_err++;
          $display("FAIL event: got cyc=%0d digit=%0d s=%b c=%b b=%b e=%b, required cyc=%0d digit=%0d s=%b c=%b b=%b e=%b",
                   cyc, digit, step_pulse, carry, borrow, load_err,
                   e.cyc, e.d, e.s, e.c, e.b, e.e);
        end
      end
    end
    if (probe && pq.size() > 0) begin
      e = pq.pop_front();
      n_vec++;
      if (digit !== e.d || step_pulse !== 1'b0 || carry !== 1'b0 || borrow !== 1'b0 ||
          load_err !== 1'b0) begin
        n_err++;
        $display("FAIL probe: cycle %0d got digit=%0d s=%b c=%b b=%b e=%b, required digit=%0d strobes 0",
                 cyc, digit, step_pulse, carry, borrow, load_err, e.d);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input logic [3:0] d, input logic s, input logic c,
                         input logic b, input logic e, input int at);
    exp_t x;
    x = '{d: d, s: s, c: c, b: b, e: e, cyc: at};
    eq.push_back(x);
  endtask

  task automatic probe_chk(input logic [3:0] d);
    exp_t x;
    x = '{d: d, s: 1'b0, c: 1'b0, b: 1'b0, e: 1'b0, cyc: -1};
    pq.push_back(x);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  // Clean press: raw high 10 cycles then low 10 cycles. A step appears 7
  // posedges after the rise (2 sync + 4 debounce + 1 output register).
  task automatic press(input logic u, input logic dn, input logic [3:0] exp_d,
                       input logic c, input logic b, input logic expect_step);
    if (expect_step) push_ev(exp_d, 1'b1, c, b, 1'b0, cyc + 7);
    btn_up   = u;
    btn_down = dn;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(10);
  endtask

  task automatic do_load(input logic [3:0] v, input logic [3:0] exp_d,
                         input logic s, input logic e);
    push_ev(exp_d, s, 1'b0, 1'b0, e, cyc + 1);
    load     = 1'b1;
    load_val = v;
    tick(1);
    load = 1'b0;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    probe_chk(4'd0);
    rst = 1'b0;
    tick(2);
    probe_chk(4'd0);

    for (int i = 1; i <= 10; i++)
      press(1'b1, 1'b0, 4'(i % 10), (i == 10), 1'b0, 1'b1);
    probe_chk(4'd0);

    press(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1);
    press(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1);

    do_load(4'd0, 4'd0, 1'b1, 1'b0);
    push_ev(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, cyc + 11);
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1; tick(20);
    btn_up = 1'b0; tick(10);
    probe_chk(4'd1);

    btn_up = 1'b1; tick(3);
    btn_up = 1'b0; tick(12);
    probe_chk(4'd1);

    do_load(4'd7, 4'd7, 1'b1, 1'b0);
    do_load(4'd12, 4'd7, 1'b0, 1'b1);
    probe_chk(4'd7);

    do_load(4'd5, 4'd5, 1'b1, 1'b0);
    press(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    probe_chk(4'd5);

    // Load lands in the very cycle the up press is presented.
    push_ev(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, cyc + 7);
    btn_up = 1'b1;
    tick(6);
    load     = 1'b1;
    load_val = 4'd3;
    tick(1);
    load = 1'b0;
    tick(3);
    btn_up = 1'b0;
    tick(10);
    probe_chk(4'd3);

    do_load(4'd4, 4'd4, 1'b1, 1'b0);
    btn_up = 1'b1;
    tick(3);
    rst = 1'b1;
    probe_chk(4'd0);
    tick(1);
    rst = 1'b0;
    push_ev(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, cyc + 7);
    tick(20);
    btn_up = 1'b0;
    tick(10);
    probe_chk(4'd1);

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
